// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared game state encodings and widths for the Flappy Bird datapath
package flappy_pkg;

    typedef logic [1:0] game_state_t;

    localparam game_state_t ST_TITLE = 2'd0;
    localparam game_state_t ST_READY = 2'd1;
    localparam game_state_t ST_PLAY  = 2'd2;
    localparam game_state_t ST_OVER  = 2'd3;

    localparam int Y_W = 11;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// rtl/flappy_game_ctrl_if.sv - button/collision inputs and game outputs of the sequencer
// Optional macro HISCORE_EN adds the hiscore signal.
interface flappy_game_ctrl_if #(
    parameter int SCORE_W = 10
);
    import flappy_pkg::*;

    logic                  btn_start;
    logic                  btn_jump;
    logic                  collide;
    logic                  pipe_passed;
    logic signed [Y_W-1:0] bird_y;
    game_state_t           state;
    logic                  enable;
    logic                  jump;
    logic [1:0]            fall_accel;
    logic [SCORE_W-1:0]    score;
`ifdef HISCORE_EN
    logic [SCORE_W-1:0]    hiscore;
`endif

    modport master (
        output btn_start, btn_jump, collide, pipe_passed, bird_y,
`ifdef HISCORE_EN
        input  hiscore,
`endif
        input  state, enable, jump, fall_accel, score
    );

    modport slave (
        input  btn_start, btn_jump, collide, pipe_passed, bird_y,
`ifdef HISCORE_EN
        output hiscore,
`endif
        output state, enable, jump, fall_accel, score
    );

endinterface

// File: rtl/flappy_tick_gen.sv
// rtl/flappy_tick_gen.sv - free-running divider producing a one-cycle tick every DIV clocks
module flappy_tick_gen #(
    parameter int DIV = 32
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/flappy_game_ctrl.sv
// rtl/flappy_game_ctrl.sv - game sequencer: state, physics tick, jump timing, score and difficulty
// Optional macro HISCORE_EN keeps a best score across games until reset.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int TICK_DIV   = 32,
    parameter int JUMP_TICKS = 2,
    parameter int SCORE_STEP = 5,
    parameter int OVER_HOLD  = 64,
    parameter int SCORE_W    = 10
) (
    input  logic               clk,
    input  logic               rst,
    flappy_game_ctrl_if.slave  gif
);
    localparam int JW = $clog2(JUMP_TICKS + 1);
    localparam int SW = $clog2(SCORE_STEP + 1);
    localparam int HW = $clog2(OVER_HOLD + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    game_state_t        state_q;
    logic               enable_q;
    logic               jump_q;
    logic [1:0]         accel_q;
    logic [SCORE_W-1:0] score_q;
    logic [JW-1:0]      jump_cnt;
    logic [SW-1:0]      step_cnt;
    logic [HW-1:0]      hold_cnt;
    logic               start_prev;
    logic               jump_prev;
    logic               tick_int;
    logic               start_edge;
    logic               jump_edge;
    logic               y_floor;
`ifdef HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;
`endif

    flappy_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_int)
    );

    assign start_edge = gif.btn_start & ~start_prev;
    assign jump_edge  = gif.btn_jump & ~jump_prev;
    // bird at or below the floor: negative or exactly zero
    assign y_floor    = gif.bird_y[Y_W-1] | (gif.bird_y == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_TITLE;
            enable_q   <= 1'b0;
            jump_q     <= 1'b0;
            accel_q    <= '0;
            score_q    <= '0;
            jump_cnt   <= '0;
            step_cnt   <= '0;
            hold_cnt   <= '0;
            start_prev <= 1'b0;
            jump_prev  <= 1'b0;
`ifdef HISCORE_EN
            hiscore_q  <= '0;
`endif
        end else begin
            start_prev <= gif.btn_start;
            jump_prev  <= gif.btn_jump;
            enable_q   <= tick_int && (state_q == ST_PLAY);
            case (state_q)
                ST_TITLE: begin
                    if (start_edge) begin
                        state_q  <= ST_READY;
                        score_q  <= '0;
                        accel_q  <= '0;
                        step_cnt <= '0;
                    end
                end
                ST_READY: begin
                    if (jump_edge) begin
                        state_q  <= ST_PLAY;
                        jump_q   <= 1'b1;
                        jump_cnt <= JW'(JUMP_TICKS);
                    end
                end
                ST_PLAY: begin
                    // a collision in the same cycle as a pipe pass takes priority
                    if (gif.collide || (tick_int && y_floor)) begin
                        state_q  <= ST_OVER;
                        jump_q   <= 1'b0;
                        jump_cnt <= '0;
                        hold_cnt <= '0;
`ifdef HISCORE_EN
                        if (score_q > hiscore_q) begin
                            hiscore_q <= score_q;
                        end
`endif
                    end else begin
                        if (jump_edge) begin
                            jump_q   <= 1'b1;
                            jump_cnt <= JW'(JUMP_TICKS);
                        end else if (tick_int && (jump_cnt != '0)) begin
                            jump_cnt <= jump_cnt - 1'b1;
                            if (jump_cnt == JW'(1)) begin
                                jump_q <= 1'b0;
                            end
                        end
                        if (gif.pipe_passed) begin
                            if (score_q != SCORE_MAX) begin
                                score_q <= score_q + 1'b1;
                            end
                            if (step_cnt == SW'(SCORE_STEP - 1)) begin
                                step_cnt <= '0;
                                if (accel_q != 2'd3) begin
                                    accel_q <= accel_q + 2'd1;
                                end
                            end else begin
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (tick_int && (hold_cnt != HW'(OVER_HOLD))) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (start_edge && (hold_cnt == HW'(OVER_HOLD))) begin
                        state_q <= ST_TITLE;
                    end
                end
                default: state_q <= ST_TITLE;
            endcase
        end
    end

    assign gif.state      = state_q;
    assign gif.enable     = enable_q;
    assign gif.jump       = jump_q;
    assign gif.fall_accel = accel_q;
    assign gif.score      = score_q;
`ifdef HISCORE_EN
    assign gif.hiscore    = hiscore_q;
`endif

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb/tb_flappy_game_ctrl.sv - directed bench for flappy_game_ctrl (hiscore checks under HISCORE_EN)
module tb_flappy_game_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    flappy_game_ctrl_if #(.SCORE_W(10)) gif ();

    flappy_game_ctrl #(
        .TICK_DIV   (4),
        .JUMP_TICKS (2),
        .SCORE_STEP (5),
        .OVER_HOLD  (64),
        .SCORE_W    (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .gif (gif)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pass_pipe(input int n);
        for (int k = 0; k < n; k++) begin
            gif.pipe_passed = 1'b1;
            cyc(1);
            gif.pipe_passed = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        int n;
        int last;
        int gap;
        int fell;
        int en_at_fall;

        rst = 1'b0;
        gif.btn_start = 1'b0;
        gif.btn_jump = 1'b0;
        gif.collide = 1'b0;
        gif.pipe_passed = 1'b0;
        gif.bird_y = 11'sd100;
        cyc(3);
        chk("rst_state", 32'(gif.state), 0);
        chk("rst_enable", 32'(gif.enable), 0);
        chk("rst_jump", 32'(gif.jump), 0);
        chk("rst_accel", 32'(gif.fall_accel), 0);
        chk("rst_score", 32'(gif.score), 0);
        n = 0;
        repeat (12) begin cyc(1); if (gif.enable) n++; end
        chk("rst_no_tick", n, 0);
        rst = 1'b1;
        cyc(2);

        gif.btn_start = 1'b1;
        cyc(1);
        chk("start_to_ready", 32'(gif.state), 1);
        cyc(3);
        chk("start_held", 32'(gif.state), 1);
        gif.btn_start = 1'b0;
        n = 0;
        repeat (12) begin cyc(1); if (gif.enable) n++; end
        chk("no_tick_ready", n, 0);

        gif.btn_jump = 1'b1;
        cyc(1);
        chk("jump_to_play", 32'(gif.state), 2);
        chk("jump_set", 32'(gif.jump), 1);
        n = 0; last = -1; gap = 0; fell = 0; en_at_fall = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (fell == 0 && gif.enable && gif.jump) n++;
            if (fell == 0 && !gif.jump) begin fell = 1; en_at_fall = 32'(gif.enable); end
            if (gif.enable) begin
                if (last >= 0) gap = i - last;
                last = i;
            end
        end
        chk("ticks_with_jump", n, 1);
        chk("jump_falls_on_tick", en_at_fall, 1);
        chk("enable_period", gap, 4);
        gif.btn_jump = 1'b0;
        cyc(1);
        gif.btn_jump = 1'b1;
        cyc(1);
        chk("jump_retrigger", 32'(gif.jump), 1);
        gif.btn_jump = 1'b0;
        cyc(12);
        chk("jump_expired", 32'(gif.jump), 0);

        for (int i = 1; i <= 20; i++) begin
            pass_pipe(1);
            if (i == 4)  chk("accel_pt4", 32'(gif.fall_accel), 0);
            if (i == 5)  chk("accel_pt5", 32'(gif.fall_accel), 1);
            if (i == 14) chk("accel_pt14", 32'(gif.fall_accel), 2);
            if (i == 15) chk("accel_pt15", 32'(gif.fall_accel), 3);
            if (i == 16) chk("score_pt16", 32'(gif.score), 16);
        end
        chk("score_pt20", 32'(gif.score), 20);
        chk("accel_sat", 32'(gif.fall_accel), 3);

        rst = 1'b0;
        cyc(1);
        chk("midgame_rst_state", 32'(gif.state), 0);
        chk("midgame_rst_score", 32'(gif.score), 0);
        chk("midgame_rst_accel", 32'(gif.fall_accel), 0);
        chk("midgame_rst_enable", 32'(gif.enable), 0);
        rst = 1'b1;
        cyc(2);

        gif.btn_start = 1'b1;
        cyc(1);
        gif.btn_start = 1'b0;
        gif.btn_jump = 1'b1;
        cyc(1);
        gif.btn_jump = 1'b0;
        chk("gameA_play", 32'(gif.state), 2);
        pass_pipe(3);
        chk("gameA_score", 32'(gif.score), 3);
        gif.collide = 1'b1;
        gif.pipe_passed = 1'b1;
        cyc(1);
        gif.collide = 1'b0;
        gif.pipe_passed = 1'b0;
        chk("collide_to_over", 32'(gif.state), 3);
        chk("collide_wins", 32'(gif.score), 3);
`ifdef HISCORE_EN
        chk("hiscore_gameA", 32'(gif.hiscore), 3);
`endif
        pass_pipe(1);
        chk("pipe_ignored_over", 32'(gif.score), 3);
        n = 0;
        repeat (8) begin cyc(1); if (gif.enable || gif.jump) n++; end
        chk("quiet_in_over", n, 0);
        cyc(30);
        gif.btn_start = 1'b1;
        cyc(1);
        gif.btn_start = 1'b0;
        cyc(1);
        chk("early_start_ignored", 32'(gif.state), 3);
        cyc(260);
        gif.btn_start = 1'b1;
        cyc(1);
        gif.btn_start = 1'b0;
        chk("late_start_title", 32'(gif.state), 0);
        chk("score_kept_title", 32'(gif.score), 3);
        cyc(1);
        gif.btn_start = 1'b1;
        cyc(1);
        gif.btn_start = 1'b0;
        chk("restart_ready", 32'(gif.state), 1);
        chk("score_cleared", 32'(gif.score), 0);

        gif.btn_jump = 1'b1;
        cyc(1);
        gif.btn_jump = 1'b0;
        pass_pipe(2);
        chk("gameB_score", 32'(gif.score), 2);
        gif.bird_y = 11'sd0;
        n = 0;
        while (gif.state != 2'd3 && n < 8) begin cyc(1); n++; end
        chk("floor_to_over", 32'(gif.state), 3);
        gif.bird_y = 11'sd100;
`ifdef HISCORE_EN
        chk("hiscore_gameB", 32'(gif.hiscore), 3);
`endif
        rst = 1'b0;
        cyc(1);
        chk("final_rst_state", 32'(gif.state), 0);
`ifdef HISCORE_EN
        chk("hiscore_rst", 32'(gif.hiscore), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
